// File: rtl/hevc_interp_pkg.sv
// Shared window geometry for the interpolation path, so the loader's window word and the
// interpolator's in_buffer agree in width by construction.
package hevc_interp_pkg;
  localparam int PIX_W    = 8;
  localparam int WIN_DIM  = 15;
  localparam int WIN_PIX  = WIN_DIM * WIN_DIM;
  localparam int WIN_BITS = PIX_W * WIN_PIX;
  localparam int CNT_W    = 8;

  typedef logic [PIX_W-1:0]    pix_t;
  typedef logic [CNT_W-1:0]    cnt_t;
  typedef logic [WIN_BITS-1:0] win_t;

  localparam cnt_t LAST_IDX = CNT_W'(WIN_PIX - 1);

  // LSB of pixel (row r, col c) inside a flat window word.
  function automatic int pix_lsb(input int r, input int c);
    return PIX_W * (c + WIN_DIM * r);
  endfunction
endpackage

// File: rtl/interp_window_bank.sv
// One window-sized register with per-pixel write enable; the written pixel is visible the cycle
// after the write edge. No backpressure: a write is always taken.
module interp_window_bank
  import hevc_interp_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic we,
  input  cnt_t idx,
  input  pix_t data,
  output win_t win
);

  win_t bank_q;
  win_t bank_d;

  always_comb begin
    bank_d = bank_q;
    for (int i = 0; i < WIN_PIX; i++) begin
      if (we && (idx == CNT_W'(i))) begin
        bank_d[i*PIX_W +: PIX_W] = data;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      bank_q <= '0;
    end else begin
      bank_q <= bank_d;
    end
  end

  assign win = bank_q;

endmodule

// File: rtl/interp_window_loader.sv
// Assembles raster pixels into ping-pong 15x15 windows; a window is valid the cycle after its
// last pixel is accepted. pix_ready drops only while the bank being filled is still held.
module interp_window_loader
  import hevc_interp_pkg::*;
(
  input  logic                clk,
  input  logic                rst,
  input  logic [PIX_W-1:0]    pix_in,
  input  logic                pix_valid,
  input  logic                pix_sof,
  output logic                pix_ready,
  output logic [WIN_BITS-1:0] win_out,
  output logic                win_valid,
  input  logic                win_ready,
  output logic [CNT_W-1:0]    fill_cnt,
  output logic                resync
);

  if (WIN_PIX > (2**CNT_W) - 1) begin : g_cnt_w_chk
    $error("interp_window_loader: WIN_PIX does not fit the fill counter");
  end

  cnt_t       wr_cnt_q, wr_cnt_d;
  logic       wr_bank_q, wr_bank_d;
  logic       rd_bank_q, rd_bank_d;
  logic [1:0] full_q, full_d;
  logic       resync_q, resync_d;

  logic       accept;
  logic       rel_win;
  cnt_t       wr_idx;
  logic [1:0] bank_we;
  win_t       bank0_win, bank1_win;

  assign pix_ready = !full_q[wr_bank_q];
  assign win_valid = full_q[rd_bank_q];
  assign accept    = pix_valid && pix_ready;
  assign rel_win   = win_valid && win_ready;

  // sof always lands in slot 0, whatever the current fill position.
  assign wr_idx     = pix_sof ? '0 : wr_cnt_q;
  assign bank_we[0] = accept && !wr_bank_q;
  assign bank_we[1] = accept && wr_bank_q;

  always_comb begin
    wr_cnt_d  = wr_cnt_q;
    wr_bank_d = wr_bank_q;
    rd_bank_d = rd_bank_q;
    full_d    = full_q;
    resync_d  = 1'b0;

    if (rel_win) begin
      full_d[rd_bank_q] = 1'b0;
      rd_bank_d         = !rd_bank_q;
    end

    // A fill can only complete into a bank that is not held, so it never
    // collides with the release above.
    if (accept) begin
      if (pix_sof) begin
        wr_cnt_d = CNT_W'(1);
        resync_d = (wr_cnt_q != '0);
      end else if (wr_cnt_q == LAST_IDX) begin
        wr_cnt_d          = '0;
        full_d[wr_bank_q] = 1'b1;
        wr_bank_d         = !wr_bank_q;
      end else begin
        wr_cnt_d = wr_cnt_q + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_cnt_q  <= '0;
      wr_bank_q <= 1'b0;
      rd_bank_q <= 1'b0;
      full_q    <= '0;
      resync_q  <= 1'b0;
    end else begin
      wr_cnt_q  <= wr_cnt_d;
      wr_bank_q <= wr_bank_d;
      rd_bank_q <= rd_bank_d;
      full_q    <= full_d;
      resync_q  <= resync_d;
    end
  end

  interp_window_bank u_bank0 (
    .clk  (clk),
    .rst  (rst),
    .we   (bank_we[0]),
    .idx  (wr_idx),
    .data (pix_in),
    .win  (bank0_win)
  );

  interp_window_bank u_bank1 (
    .clk  (clk),
    .rst  (rst),
    .we   (bank_we[1]),
    .idx  (wr_idx),
    .data (pix_in),
    .win  (bank1_win)
  );

  assign win_out  = rd_bank_q ? bank1_win : bank0_win;
  assign fill_cnt = wr_cnt_q;
  assign resync   = resync_q;

endmodule

// File: tb/tb_interp_window_loader.sv
// Bench for interp_window_loader: cycle model plus window scoreboard, byte table, corner sequences.
module tb_interp_window_loader;
  import hevc_interp_pkg::*;

  logic                clk = 1'b0;
  logic                rst = 1'b1;
  logic [PIX_W-1:0]    pix_in = '0;
  logic                pix_valid = 1'b0;
  logic                pix_sof = 1'b0;
  logic                pix_ready;
  logic [WIN_BITS-1:0] win_out;
  logic                win_valid;
  logic                win_ready = 1'b0;
  logic [CNT_W-1:0]    fill_cnt;
  logic                resync;

  always #5 clk = ~clk;

  interp_window_loader dut (
    .clk       (clk),
    .rst       (rst),
    .pix_in    (pix_in),
    .pix_valid (pix_valid),
    .pix_sof   (pix_sof),
    .pix_ready (pix_ready),
    .win_out   (win_out),
    .win_valid (win_valid),
    .win_ready (win_ready),
    .fill_cnt  (fill_cnt),
    .resync    (resync)
  );

  int n_tests = 0;
  int n_fail  = 0;
  int n_win   = 0;

  // Reference model state
  logic [WIN_BITS-1:0] m_bank [2];
  logic [1:0]          m_full;
  logic                m_wb, m_rb, m_resync;
  int                  m_cnt;
  logic [WIN_BITS-1:0] exp_q [$];

  typedef struct {
    int         r;
    int         c;
    logic [7:0] exp;
  } vec_t;
  vec_t tbl [7];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic chkw(input string name, input logic [WIN_BITS-1:0] act,
                      input logic [WIN_BITS-1:0] exp);
    int bad;
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      bad = 0;
      for (int i = WIN_PIX - 1; i >= 0; i--)
        if (act[PIX_W*i +: PIX_W] !== exp[PIX_W*i +: PIX_W]) bad = i;
      $display("FAIL %s: byte %0d got %0h expected %0h at %0t", name, bad,
               act[PIX_W*bad +: PIX_W], exp[PIX_W*bad +: PIX_W], $time);
    end
  endtask

  task automatic model_reset();
    m_bank[0] = '0;
    m_bank[1] = '0;
    m_full    = '0;
    m_wb      = 1'b0;
    m_rb      = 1'b0;
    m_resync  = 1'b0;
    m_cnt     = 0;
    exp_q.delete();
  endtask

  // Advance the model by one clock using the inputs currently driven.
  task automatic model_step();
    logic       acc, rel;
    logic [1:0] nf;
    acc      = pix_valid && !m_full[m_wb];
    rel      = m_full[m_rb] && win_ready;
    nf       = m_full;
    m_resync = 1'b0;
    if (rel) begin
      nf[m_rb] = 1'b0;
      m_rb     = !m_rb;
    end
    if (acc) begin
      if (pix_sof) begin
        m_resync                 = (m_cnt != 0);
        m_bank[m_wb][PIX_W-1:0] = pix_in;
        m_cnt                    = 1;
      end else begin
        m_bank[m_wb][PIX_W*m_cnt +: PIX_W] = pix_in;
        if (m_cnt == WIN_PIX - 1) begin
          exp_q.push_back(m_bank[m_wb]);
          nf[m_wb] = 1'b1;
          m_wb     = !m_wb;
          m_cnt    = 0;
        end else begin
          m_cnt++;
        end
      end
    end
    m_full = nf;
  endtask

  task automatic check_outputs();
    chk("pix_ready", pix_ready, !m_full[m_wb]);
    chk("win_valid", win_valid, m_full[m_rb]);
    chk("fill_cnt", fill_cnt, m_cnt);
    chk("resync", resync, m_resync);
    chkw("win_out", win_out, m_bank[m_rb]);
  endtask

  // Inputs are set just after an edge; this consumes the next edge.
  task automatic tick();
    if (m_full[m_rb] && win_ready) begin
      if (exp_q.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL sb_window: release with no expected window at %0t", $time);
      end else begin
        chkw("sb_window", win_out, exp_q.pop_front());
      end
      n_win++;
    end
    model_step();
    @(posedge clk);
    #1;
    check_outputs();
  endtask

  task automatic send(input logic [7:0] d);
    pix_valid = 1'b1;
    pix_in    = d;
    pix_sof   = 1'b0;
    tick();
  endtask

  task automatic idle_release();
    pix_valid = 1'b0;
    win_ready = 1'b1;
    tick();
    win_ready = 1'b0;
  endtask

  task automatic check_table(input string tag);
    for (int i = 0; i < 7; i++)
      chk({tag, "_byte"}, win_out[pix_lsb(tbl[i].r, tbl[i].c) +: PIX_W], tbl[i].exp);
  endtask

  task automatic run_ramp_window(input string tag);
    for (int k = 0; k < WIN_PIX; k++) begin
      if (k == WIN_PIX - 1) chk({tag, "_valid_early"}, win_valid, 0);
      send(8'(k));
    end
    chk({tag, "_valid"}, win_valid, 1);
    chk({tag, "_bits399"}, win_out[399:392], 8'h31);
    check_table(tag);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int base;
    tbl[0] = '{0, 0, 8'h00};
    tbl[1] = '{0, 1, 8'h01};
    tbl[2] = '{3, 4, 8'h31};
    tbl[3] = '{0, 14, 8'h0E};
    tbl[4] = '{14, 0, 8'hD2};
    tbl[5] = '{14, 14, 8'hE0};
    tbl[6] = '{7, 7, 8'h70};

    model_reset();
    #2 rst = 1'b0;
    #10;
    chk("rst_pix_ready", pix_ready, 1);
    chk("rst_win_valid", win_valid, 0);
    chk("rst_fill_cnt", fill_cnt, 0);
    chk("rst_resync", resync, 0);
    chkw("rst_win_out", win_out, '0);
    @(negedge clk) rst = 1'b1;
    @(posedge clk);
    #1;

    // 1: first window, raster ramp
    run_ramp_window("t1");

    // 2: second bank fills while the first is held, then one release
    for (int k = 225; k < 450; k++) send(8'(k));
    chk("t2_ready_low", pix_ready, 0);
    chk("t2_still_first", win_out[7:0], 8'h00);
    send(8'(450));
    chk("t2_held_cnt", fill_cnt, 0);
    chk("t2_held_ready", pix_ready, 0);
    win_ready = 1'b1;
    tick();
    win_ready = 1'b0;
    chk("t2_valid", win_valid, 1);
    chk("t2_second_byte0", win_out[7:0], 8'hE1);
    chk("t2_ready_back", pix_ready, 1);

    // 3: release coinciding with fill completion
    for (int k = 450; k < 675; k++) send(8'(k));
    idle_release();
    chk("t3_bank0_byte0", win_out[7:0], 8'hC2);
    for (int k = 675; k < 900; k++) begin
      win_ready = (k == 899);
      send(8'(k));
    end
    win_ready = 1'b0;
    chk("t3_valid", win_valid, 1);
    chk("t3_bank1_byte0", win_out[7:0], 8'hA3);
    chk("t3_ready", pix_ready, 1);
    chk("t3_cnt", fill_cnt, 0);
    idle_release();
    chk("t3_drained", win_valid, 0);

    // 4: sof mid-fill
    for (int k = 0; k < 100; k++) send(8'(k + 16));
    chk("t4_cnt100", fill_cnt, 100);
    pix_valid = 1'b1;
    pix_in    = 8'hAA;
    pix_sof   = 1'b1;
    tick();
    pix_sof = 1'b0;
    chk("t4_resync", resync, 1);
    chk("t4_cnt1", fill_cnt, 1);
    for (int j = 1; j <= 224; j++) begin
      send(8'(j));
      if (j == 1) chk("t4_resync_off", resync, 0);
      if (j == 223) chk("t4_valid_early", win_valid, 0);
    end
    chk("t4_valid", win_valid, 1);
    chk("t4_byte0", win_out[7:0], 8'hAA);
    chk("t4_byte1", win_out[15:8], 8'h01);
    idle_release();

    // 5: asynchronous reset mid-fill, then a fresh ramp
    for (int k = 0; k < 150; k++) send(8'(k + 3));
    chk("t5_cnt150", fill_cnt, 150);
    pix_valid = 1'b0;
    #3 rst = 1'b0;
    model_reset();
    #1;
    chk("t5_pix_ready", pix_ready, 1);
    chk("t5_win_valid", win_valid, 0);
    chk("t5_fill_cnt", fill_cnt, 0);
    chk("t5_resync", resync, 0);
    chkw("t5_win_out", win_out, '0);
    #2 rst = 1'b1;
    @(posedge clk);
    #1;
    run_ramp_window("t5");
    idle_release();

    // 6: random source gaps and random consumer
    base = n_win;
    for (int cyc = 0; cyc < 6000 && (n_win - base) < 4; cyc++) begin
      pix_valid = ($urandom_range(0, 99) < 40);
      pix_in    = 8'($urandom);
      pix_sof   = 1'b0;
      win_ready = ($urandom_range(0, 3) == 0);
      tick();
    end
    pix_valid = 1'b0;
    win_ready = 1'b0;
    chk("t6_windows", n_win - base, 4);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
